// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - chan_state_e : per-channel supervisor state, fixed 3-bit encodings
//   - cnt_width()  : counter width able to hold values 0 .. max_val-1 (min 1 bit)
//   - max3()       : largest of three cycle parameters, sizes the shared counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RST_PULSE  = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE_CHK = 3'd2,
    LOCKED     = 3'd3,
    FAILED     = 3'd4
  } chan_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// -----------------------------------------------------------------------------
// pll_lock_chan
// Supervises one PLL: synchronises its LOCK output, pulses its RESET pin,
// qualifies lock with a stability window, retries on timeout and parks in
// FAILED after MAX_RETRY consecutive timeouts.
//
// Ports:
//   clkin        in   reference clock
//   reset        in   synchronous active-high reset
//   i_pll_lock   in   raw PLL LOCK, asynchronous to clkin
//   i_clear_fail in   single-cycle request to leave FAILED
//   o_pll_reset  out  PLL RESET pin drive, active high
//   o_dom_rst    out  domain reset, low only while LOCKED
//   o_pll_fail   out  high while FAILED
//   o_lock_loss  out  one-cycle pulse when a LOCKED channel drops lock
//   o_locked     out  high while LOCKED (feeds the all_locked AND)
// -----------------------------------------------------------------------------
module pll_lock_chan
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3
) (
  input  logic clkin,
  input  logic reset,
  input  logic i_pll_lock,
  input  logic i_clear_fail,
  output logic o_pll_reset,
  output logic o_dom_rst,
  output logic o_pll_fail,
  output logic o_lock_loss,
  output logic o_locked
);

  localparam int CW = cnt_width(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC));
  localparam int RW = cnt_width(MAX_RETRY + 1);

  // Terminal counts: each window ends on the cycle the counter holds N-1.
  localparam logic [CW-1:0] C_RST_LAST     = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] C_STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] C_RETRY_MAX    = RW'(MAX_RETRY);

  logic          r_sync1;
  logic          r_lock_s;
  chan_state_e   r_state;
  chan_state_e   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_retry_next;
  logic [RW-1:0] w_retry_inc;
  logic          w_lock_loss_next;
  logic          r_pll_reset;
  logic          r_dom_rst;
  logic          r_pll_fail;
  logic          r_lock_loss;
  logic          r_locked;

  // Two-flop synchroniser; the FSM only ever looks at r_lock_s.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= i_pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_retry_next     = r_retry;
    w_lock_loss_next = 1'b0;
    w_retry_inc      = r_retry + RW'(1);
    case (r_state)
      RST_PULSE: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_next = WAIT_LOCK;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins over the retry.
        if (r_lock_s) begin
          w_state_next = STABLE_CHK;
          w_cnt_next   = '0;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_retry_next = w_retry_inc;
          w_cnt_next   = '0;
          w_state_next = (w_retry_inc == C_RETRY_MAX) ? FAILED : RST_PULSE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      STABLE_CHK: begin
        // A dropout restarts the lock wait without costing a retry.
        if (!r_lock_s) begin
          w_state_next = WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_next = LOCKED;
          w_cnt_next   = '0;
          w_retry_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      LOCKED: begin
        if (!r_lock_s) begin
          w_state_next     = RST_PULSE;
          w_cnt_next       = '0;
          w_lock_loss_next = 1'b1;
        end
      end
      FAILED: begin
        w_cnt_next = '0;
        if (i_clear_fail) begin
          w_state_next = RST_PULSE;
          w_retry_next = '0;
        end
      end
      default: begin
        w_state_next = RST_PULSE;
        w_cnt_next   = '0;
        w_retry_next = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state <= RST_PULSE;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_retry <= w_retry_next;
    end
  end

  // Outputs decode the next state so they change on the edge the state is entered.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_pll_reset <= 1'b1;
      r_dom_rst   <= 1'b1;
      r_pll_fail  <= 1'b0;
      r_lock_loss <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_pll_reset <= (w_state_next == RST_PULSE) || (w_state_next == FAILED);
      r_dom_rst   <= (w_state_next != LOCKED);
      r_pll_fail  <= (w_state_next == FAILED);
      r_lock_loss <= w_lock_loss_next;
      r_locked    <= (w_state_next == LOCKED);
    end
  end

  assign o_pll_reset = r_pll_reset;
  assign o_dom_rst   = r_dom_rst;
  assign o_pll_fail  = r_pll_fail;
  assign o_lock_loss = r_lock_loss;
  assign o_locked    = r_locked;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Supervises NUM_PLL rPLL instances from the board reference clock: one
// pll_lock_chan per PLL plus a registered all-channels-locked flag.
//
// Ports:
//   clkin       in   reference clock, the only clock
//   reset       in   synchronous active-high reset
//   pll_lock    in   raw PLL LOCK outputs (asynchronous)
//   clear_fail  in   per-channel request to leave FAILED
//   pll_reset   out  PLL RESET pin drives, active high
//   dom_rst     out  per-domain resets, low only while that channel is LOCKED
//   all_locked  out  high when every channel is LOCKED (one extra register stage)
//   pll_fail    out  per-channel FAILED flag
//   lock_loss   out  per-channel one-cycle lock-loss pulse
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_PLL          = 2,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic [NUM_PLL-1:0] pll_lock,
  input  logic [NUM_PLL-1:0] clear_fail,
  output logic [NUM_PLL-1:0] pll_reset,
  output logic [NUM_PLL-1:0] dom_rst,
  output logic               all_locked,
  output logic [NUM_PLL-1:0] pll_fail,
  output logic [NUM_PLL-1:0] lock_loss
);

  logic [NUM_PLL-1:0] w_locked;
  logic               r_all_locked;

  generate
    for (genvar gi = 0; gi < NUM_PLL; gi++) begin : g_chan
      pll_lock_chan #(
        .RST_PULSE_CYC    (RST_PULSE_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .MAX_RETRY        (MAX_RETRY)
      ) u_chan (
        .clkin        (clkin),
        .reset        (reset),
        .i_pll_lock   (pll_lock[gi]),
        .i_clear_fail (clear_fail[gi]),
        .o_pll_reset  (pll_reset[gi]),
        .o_dom_rst    (dom_rst[gi]),
        .o_pll_fail   (pll_fail[gi]),
        .o_lock_loss  (lock_loss[gi]),
        .o_locked     (w_locked[gi])
      );
    end
  endgenerate

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_all_locked <= 1'b0;
    end else begin
      r_all_locked <= &w_locked;
    end
  end

  assign all_locked = r_all_locked;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int NP = 2;
  localparam int RP = 4;
  localparam int ST = 8;
  localparam int TO = 32;
  localparam int MR = 2;

  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_LOCK  = 3;
  localparam int P_FAIL  = 4;

  logic          clkin = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] pll_lock = '0;
  logic [NP-1:0] clear_fail = '0;
  logic [NP-1:0] pll_reset;
  logic [NP-1:0] dom_rst;
  logic          all_locked;
  logic [NP-1:0] pll_fail;
  logic [NP-1:0] lock_loss;

  pll_lock_supervisor #(
    .NUM_PLL          (NP),
    .RST_PULSE_CYC    (RP),
    .LOCK_STABLE_CYC  (ST),
    .LOCK_TIMEOUT_CYC (TO),
    .MAX_RETRY        (MR)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .clear_fail (clear_fail),
    .pll_reset  (pll_reset),
    .dom_rst    (dom_rst),
    .all_locked (all_locked),
    .pll_fail   (pll_fail),
    .lock_loss  (lock_loss)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  // Behavioural model: each channel is a phase plus the edge it was entered.
  // Windows are measured as elapsed edges since entry; lock_s is the raw
  // input as sampled two edges earlier.
  int  m_ph    [NP];
  int  m_t0    [NP];
  int  m_retry [NP];
  bit  m_hist1 [NP];
  bit  m_hist2 [NP];
  bit  m_loss  [NP];
  bit  m_valid = 1'b0;
  logic [NP-1:0] e_pll_reset, e_dom_rst, e_fail, e_loss;
  logic          e_all;

  always @(posedge clkin) begin
    bit all_prev;
    bit ls;
    cyc = cyc + 1;
    all_prev = 1'b1;
    for (int c = 0; c < NP; c++) if (m_ph[c] != P_LOCK) all_prev = 1'b0;
    e_all = (reset || !m_valid) ? 1'b0 : all_prev;
    if (reset) m_valid = 1'b1;
    for (int c = 0; c < NP; c++) begin
      m_loss[c] = 1'b0;
      if (reset) begin
        m_ph[c] = P_PULSE; m_t0[c] = cyc; m_retry[c] = 0;
        m_hist1[c] = 1'b0; m_hist2[c] = 1'b0;
      end else begin
        ls = m_hist2[c];
        m_hist2[c] = m_hist1[c];
        m_hist1[c] = pll_lock[c];
        case (m_ph[c])
          P_PULSE: if (cyc - m_t0[c] == RP) begin m_ph[c] = P_WAIT; m_t0[c] = cyc; end
          P_WAIT: begin
            if (ls) begin
              m_ph[c] = P_STAB; m_t0[c] = cyc;
            end else if (cyc - m_t0[c] == TO) begin
              m_retry[c] = m_retry[c] + 1;
              m_ph[c] = (m_retry[c] == MR) ? P_FAIL : P_PULSE;
              m_t0[c] = cyc;
            end
          end
          P_STAB: begin
            if (!ls) begin m_ph[c] = P_WAIT; m_t0[c] = cyc; end
            else if (cyc - m_t0[c] == ST) begin m_ph[c] = P_LOCK; m_retry[c] = 0; end
          end
          P_LOCK: if (!ls) begin m_ph[c] = P_PULSE; m_t0[c] = cyc; m_loss[c] = 1'b1; end
          default: if (clear_fail[c]) begin m_ph[c] = P_PULSE; m_t0[c] = cyc; m_retry[c] = 0; end
        endcase
      end
      e_pll_reset[c] = (m_ph[c] == P_PULSE) || (m_ph[c] == P_FAIL);
      e_dom_rst[c]   = (m_ph[c] != P_LOCK);
      e_fail[c]      = (m_ph[c] == P_FAIL);
      e_loss[c]      = m_loss[c];
    end
  end

  // Edge monitor state, updated in tick()
  logic [NP-1:0] pr_prev = '1, dom_prev = '1, fail_prev = '0;
  logic al_prev = 1'b0;
  int pr_h0 [NP], pr_h1 [NP], pr_h2 [NP], pr_fall [NP];
  int dom_fall [NP], dom_rise [NP], dom_fall_cnt [NP];
  int fail_rise [NP], fail_fall [NP], ll_cyc [NP], ll_cnt [NP];
  int al_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clkin);
    if (m_valid) begin
      chk("pll_reset", 32'(pll_reset), 32'(e_pll_reset));
      chk("dom_rst", 32'(dom_rst), 32'(e_dom_rst));
      chk("pll_fail", 32'(pll_fail), 32'(e_fail));
      chk("lock_loss", 32'(lock_loss), 32'(e_loss));
      chk("all_locked", 32'(all_locked), 32'(e_all));
    end
    for (int c = 0; c < NP; c++) begin
      if (!pr_prev[c] && pll_reset[c]) begin
        pr_h2[c] = pr_h1[c]; pr_h1[c] = pr_h0[c]; pr_h0[c] = cyc;
      end
      if (pr_prev[c] && !pll_reset[c]) pr_fall[c] = cyc;
      if (dom_prev[c] && !dom_rst[c]) begin dom_fall[c] = cyc; dom_fall_cnt[c]++; end
      if (!dom_prev[c] && dom_rst[c]) dom_rise[c] = cyc;
      if (!fail_prev[c] && pll_fail[c]) fail_rise[c] = cyc;
      if (fail_prev[c] && !pll_fail[c]) fail_fall[c] = cyc;
      if (lock_loss[c]) begin ll_cyc[c] = cyc; ll_cnt[c]++; end
    end
    if (!al_prev && all_locked) al_rise = cyc;
    pr_prev = pll_reset; dom_prev = dom_rst; fail_prev = pll_fail; al_prev = all_locked;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 32'h3);
    chk({tag, "_dom_rst"}, 32'(dom_rst), 32'h3);
    chk({tag, "_all_locked"}, 32'(all_locked), 32'h0);
    chk({tag, "_pll_fail"}, 32'(pll_fail), 32'h0);
    chk({tag, "_lock_loss"}, 32'(lock_loss), 32'h0);
  endtask

  int t_rel, t_r0, t_r1, t_d, t_c;
  int run_left [NP];

  initial begin
    // Reset state
    ticks(3);
    chk_reset_vals("reset");
    reset = 1'b0; t_rel = cyc;

    // 1+2. Clean bring-up on ch0, glitchy lock on ch1
    ticks(10);
    t_r0 = cyc; pll_lock = 2'b11;
    ticks(5);
    pll_lock[1] = 1'b0;
    tick();
    pll_lock[1] = 1'b1; t_r1 = cyc;
    ticks(15);
    chk("bringup_pulse_len", 32'(pr_fall[0] - t_rel), 32'(RP));
    chk("bringup_dom0_latency", 32'(dom_fall[0] - t_r0), 32'd11);
    chk("glitch_dom1_latency", 32'(dom_fall[1] - t_r1), 32'd11);
    chk("glitch_single_lock_entry", 32'(dom_fall_cnt[1]), 32'd1);
    chk("all_locked_delay", 32'(al_rise - dom_fall[1]), 32'd1);

    // 3. Lock loss on ch0, then relock
    t_d = cyc; pll_lock[0] = 1'b0;
    ticks(6);
    pll_lock[0] = 1'b1;
    ticks(20);
    chk("lossA_latency", 32'(ll_cyc[0] - t_d), 32'd3);
    chk("lossA_single_pulse", 32'(ll_cnt[0]), 32'd1);
    chk("lossA_pll_reset_same_cycle", 32'(pr_h0[0]), 32'(ll_cyc[0]));
    chk("lossA_dom_rst_same_cycle", 32'(dom_rise[0]), 32'(ll_cyc[0]));
    chk("lossA_pulse_len", 32'(pr_fall[0] - pr_h0[0]), 32'(RP));
    chk("lossA_relocked", 32'(dom_rst[0]), 32'd0);

    // 4. Timeout and fail on ch1
    pll_lock[1] = 1'b0;
    ticks(80);
    chk("timeout_pulse_spacing1", 32'(pr_h1[1] - pr_h2[1]), 32'(RP + TO));
    chk("timeout_pulse_spacing2", 32'(pr_h0[1] - pr_h1[1]), 32'(RP + TO));
    chk("fail_entry_cycle", 32'(fail_rise[1]), 32'(pr_h0[1]));
    chk("fail_flag", 32'(pll_fail), 32'b10);
    chk("fail_pll_reset_held", 32'(pll_reset[1]), 32'd1);
    chk("fail_ch0_unaffected", 32'(dom_rst[0]), 32'd0);

    // 5. Recovery by clear_fail, then clear_fail while LOCKED
    t_c = cyc; clear_fail[1] = 1'b1; pll_lock[1] = 1'b1;
    tick();
    clear_fail[1] = 1'b0;
    ticks(20);
    chk("clear_fail_drop", 32'(fail_fall[1] - t_c), 32'd1);
    chk("clear_pulse_end", 32'(pr_fall[1] - t_c), 32'(RP + 1));
    chk("clear_relock_all", 32'(all_locked), 32'd1);
    clear_fail[0] = 1'b1;
    tick();
    clear_fail[0] = 1'b0;
    ticks(4);
    chk("clear_ignored_locked", 32'(dom_rst[0]), 32'd0);

    // 6a. Reset mid STABLE_CHK
    pll_lock[1] = 1'b0;
    ticks(5);
    pll_lock[1] = 1'b1;
    ticks(5);
    chk("stab_dom_rst", 32'(dom_rst[1]), 32'd1);
    chk("stab_pll_reset", 32'(pll_reset[1]), 32'd0);
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_stab");
    reset = 1'b0;

    // 6b. Reset mid FAILED
    pll_lock[1] = 1'b0;
    ticks(80);
    chk("prefail_flag", 32'(pll_fail[1]), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_fail");
    reset = 1'b0;
    ticks(3);
    chk("restart_pulse", 32'(pll_reset), 32'h3);

    // Randomised phase: long lock runs with drops, clear_fail and rare resets
    for (int c = 0; c < NP; c++) run_left[c] = $urandom_range(1, 100);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NP; c++) begin
        run_left[c]--;
        if (run_left[c] <= 0) begin
          pll_lock[c] = ~pll_lock[c];
          run_left[c] = pll_lock[c] ? $urandom_range(1, 200) : $urandom_range(1, 120);
        end
        clear_fail[c] = ($urandom_range(0, 49) == 0);
      end
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0; clear_fail = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
